sync_fifo_wr_arbiter: RTL

//  Round-robin write arbiter sharing one synchronous FIFO write port among NUM_REQ producers.
//  - Grants one producer at a time; the granted producer may write a burst of up to MAX_BURST words.
//  - Drives the FIFO wrt_en/data_in pair and honours the FIFO full flag.
//  - Sits directly in front of the 16-bit, 8-deep synchronous FIFO.

---
 rtl/sync_fifo_wr_arbiter.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/sync_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// sync_fifo_wr_arbiter
//   Round-robin arbiter that shares the write port of a synchronous FIFO
//   among NUM_REQ producers. Only one producer owns the port at a time.
//   The owner may write a burst of up to MAX_BURST words before the port is
//   re-arbitrated. The FIFO full flag stalls the owner without losing its
//   grant.
//
// Optional feature:
//   SYNC_FIFO_ARB_STATS_EN  when defined, stall_cnt counts the cycles in which
//                           the owner has a word ready but the FIFO is full.
//                           The count saturates at 16'hFFFF. When undefined,
//                           stall_cnt is tied to zero.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   req           producer i has a valid word on its req_data slice
//   req_last      producer i's current word ends its burst
//   req_data      producer i's word at [i*DATA_W +: DATA_W]
//   gnt           registered one-hot owner; zero when idle
//   accept        one-hot; producer i's word is written this cycle
//   fifo_full     FIFO full flag
//   fifo_wrt_en   FIFO write enable
//   fifo_data_in  FIFO write data (zero when no owner)
//   stall_cnt     full-stall cycle count (see above)
// -----------------------------------------------------------------------------
module sync_fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        accept,
    input  logic                      fifo_full,
    output logic                      fifo_wrt_en,
    output logic [DATA_W-1:0]         fifo_data_in,
    output logic [15:0]               stall_cnt
);

    localparam int             PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0]     BURST_LAST = 4'(MAX_BURST - 1);
    localparam logic [PTR_W-1:0] PTR_RESET = PTR_W'(NUM_REQ - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [3:0]         burst_cnt, burst_cnt_nxt;

    logic               wrote;
    logic               owner_req;
    logic               owner_last;
    logic               release_now;
    logic [NUM_REQ-1:0] pending;
    logic               found;
    logic [PTR_W-1:0]   pick_idx;
    int                 idx;

    // ------------------------------------------------------------------
    // Write path: purely combinational from the registered grant.
    // ------------------------------------------------------------------
    assign accept      = gnt & req & {NUM_REQ{~fifo_full}};
    assign fifo_wrt_en = |accept;
    assign wrote       = fifo_wrt_en;
    assign owner_req   = |(gnt & req);
    assign owner_last  = |(gnt & req_last);

    always_comb begin
        fifo_data_in = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                fifo_data_in = fifo_data_in | req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // A burst ends on its marked last word, on its MAX_BURST-th word, or
    // as soon as the owner withdraws its request.
    assign release_now = (wrote && (owner_last || burst_cnt == BURST_LAST)) || !owner_req;

    // ------------------------------------------------------------------
    // Round-robin search starting one past the last winner. A word being
    // written this cycle is consumed, so its producer is not counted as
    // pending; the previous owner is naturally searched last.
    // ------------------------------------------------------------------
    assign pending = req & ~accept;

    always_comb begin
        found    = 1'b0;
        pick_idx = rr_ptr;
        idx      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && pending[idx[PTR_W-1:0]]) begin
                found    = 1'b1;
                pick_idx = idx[PTR_W-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_nxt     = state;
        gnt_nxt       = gnt;
        rr_ptr_nxt    = rr_ptr;
        burst_cnt_nxt = burst_cnt;

        unique case (state)
            IDLE: begin
                if (found) begin
                    state_nxt           = GRANT;
                    gnt_nxt             = '0;
                    gnt_nxt[pick_idx]   = 1'b1;
                    rr_ptr_nxt          = pick_idx;
                    burst_cnt_nxt       = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    burst_cnt_nxt = '0;
                    if (found) begin
                        gnt_nxt           = '0;
                        gnt_nxt[pick_idx] = 1'b1;
                        rr_ptr_nxt        = pick_idx;
                    end else begin
                        state_nxt = IDLE;
                        gnt_nxt   = '0;
                    end
                end else if (wrote) begin
                    burst_cnt_nxt = burst_cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            rr_ptr    <= PTR_RESET;
            burst_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state     <= state_nxt;
            gnt       <= gnt_nxt;
            rr_ptr    <= rr_ptr_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Optional full-stall statistics.
    // ------------------------------------------------------------------
`ifdef SYNC_FIFO_ARB_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (owner_req && fifo_full && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'h0;
`endif

endmodule
